// File: rtl/likesram_to_axi.sv
// likesram_to_axi: bridges inst/data SRAM-like ports onto one single-beat AXI3 master, one transaction at a time
module likesram_to_axi (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        done;

   // State and latched request registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         wr_q      <= 1'b0;
         size_q    <= 2'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         wr_q      <= wr_d;
         size_q    <= size_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Arbitration (data port wins), request capture and AXI handshake sequencing
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      wr_d      = wr_q;
      size_d    = size_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: if (data_req || inst_req) begin
            owner_d   = data_req;
            wr_d      = data_req ? data_wr    : inst_wr;
            size_d    = data_req ? data_size  : inst_size;
            addr_d    = data_req ? data_addr  : inst_addr;
            wdata_d   = data_req ? data_wdata : inst_wdata;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = wr_d ? WR_ADDR : RD_ADDR;
         end
         RD_ADDR: if (arready) state_d = RD_DATA;
         RD_DATA: if (rvalid) state_d = IDLE;
         WR_ADDR: begin
            aw_done_d = aw_done_q || awready;
            w_done_d  = w_done_q || wready;
            if (aw_done_d && w_done_d) state_d = WR_RESP;
         end
         WR_RESP: if (bvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign data_addr_ok = (state_q == IDLE) && data_req;
   assign inst_addr_ok = (state_q == IDLE) && !data_req && inst_req;
   assign done         = ((state_q == RD_DATA) && rvalid) || ((state_q == WR_RESP) && bvalid);
   assign data_data_ok = done && owner_q;
   assign inst_data_ok = done && !owner_q;
   assign data_rdata   = (data_data_ok && !wr_q) ? rdata : 32'd0;
   assign inst_rdata   = (inst_data_ok && !wr_q) ? rdata : 32'd0;

   assign arid    = {3'b000, owner_q};
   assign araddr  = addr_q;
   assign arlen   = 8'd0;
   assign arsize  = {1'b0, size_q};
   assign arburst = 2'b01;
   assign arlock  = 2'd0;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign arvalid = (state_q == RD_ADDR);
   assign rready  = (state_q == RD_DATA);

   assign awid    = 4'd1;
   assign awaddr  = addr_q;
   assign awlen   = 8'd0;
   assign awsize  = {1'b0, size_q};
   assign awburst = 2'b01;
   assign awlock  = 2'd0;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;
   assign awvalid = (state_q == WR_ADDR) && !aw_done_q;
   assign wid     = 4'd1;
   assign wdata   = wdata_q;
   assign wlast   = 1'b1;
   assign wvalid  = (state_q == WR_ADDR) && !w_done_q;
   assign wstrb   = (size_q == 2'd0) ? (4'b0001 << addr_q[1:0]) :
                    (size_q == 2'd1) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign bready  = (state_q == WR_RESP);

endmodule
